// File: rtl/uart_pkg.sv
// Shared UART definitions: line states, framing width and the
// clock-divider helper, used by both the transmitter and receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } txState_t;

    localparam int DATA_BITS = 8;
    localparam int DIV_WIDTH = 12;

    function automatic int clkDiv(input int clkFreq, input int baud);
        return clkFreq / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a separate occupancy counter; pushes
// when full and pops when empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int LOG2  = 4
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iPush,
    input  logic [WIDTH-1:0] iData,
    input  logic             iPop,
    output logic [WIDTH-1:0] oData,
    output logic             oFull,
    output logic             oEmpty,
    output logic [LOG2:0]    oCount
);

    localparam int DEPTH = 2 ** LOG2;
    localparam logic [LOG2:0] FULL_CNT = {1'b1, {LOG2{1'b0}}};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [LOG2-1:0]  wrPtr;
    logic [LOG2-1:0]  rdPtr;
    logic [LOG2:0]    count;
    logic             doPush;
    logic             doPop;

    assign oFull  = (count == FULL_CNT);
    assign oEmpty = (count == '0);
    assign oCount = count;
    assign oData  = mem[rdPtr];
    assign doPush = iPush && !oFull;
    assign doPop  = iPop && !oEmpty;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge iClk) begin
        if (!iRst && doPush) mem[wrPtr] <= iData;
    end

endmodule

// File: rtl/uart_tx.sv
// Byte-wide 8N1 UART transmitter with configurable stop bits,
// fed from a small FIFO so producers rarely stall.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 25000000,
    parameter int BAUD      = 115200,
    parameter int CLK_DIV   = clkDiv(CLK_FREQ, BAUD),
    parameter int STOP_BITS = 1,
    parameter int FIFO_LOG2 = 4
) (
    input  logic                 iClk,
    input  logic                 iRst,
    input  logic [7:0]           iData,
    input  logic                 iValid,
    output logic                 oReady,
    output logic                 oTx,
    output logic                 oBusy,
    output logic [FIFO_LOG2:0]   oCount
);

    localparam logic [DIV_WIDTH-1:0] DIV_LOAD = DIV_WIDTH'(CLK_DIV - 1);
    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic       STOP_LAST = (STOP_BITS == 2);

    txState_t             state;
    logic [DIV_WIDTH-1:0] divCnt;
    logic [2:0]           bitCnt;
    logic                 stopCnt;
    logic [7:0]           shifter;
    logic [7:0]           fifoData;
    logic                 fifoFull;
    logic                 fifoEmpty;
    logic                 fifoPop;
    logic                 bitDone;
    logic                 lastStop;

    sync_fifo #(
        .WIDTH (8),
        .LOG2  (FIFO_LOG2)
    ) fifo (
        .iClk   (iClk),
        .iRst   (iRst),
        .iPush  (iValid),
        .iData  (iData),
        .iPop   (fifoPop),
        .oData  (fifoData),
        .oFull  (fifoFull),
        .oEmpty (fifoEmpty),
        .oCount (oCount)
    );

    assign oReady   = !fifoFull;
    assign bitDone  = (divCnt == '0);
    assign lastStop = bitDone && (stopCnt == STOP_LAST);
    // Pop from idle, or straight out of the final stop bit for gapless frames
    assign fifoPop  = !fifoEmpty &&
                      (state == IDLE || (state == STOP && lastStop));

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state   <= IDLE;
            divCnt  <= '0;
            bitCnt  <= '0;
            stopCnt <= 1'b0;
            shifter <= '0;
            oTx     <= 1'b1;
            oBusy   <= 1'b0;
        end else begin
            oBusy <= !fifoEmpty || (state != IDLE);
            case (state)
                IDLE: begin
                    oTx <= 1'b1;
                    if (fifoPop) begin
                        shifter <= fifoData;
                        divCnt  <= DIV_LOAD;
                        state   <= START;
                    end
                end
                START: begin
                    oTx <= 1'b0;
                    if (bitDone) begin
                        divCnt <= DIV_LOAD;
                        bitCnt <= '0;
                        state  <= DATA;
                    end else begin
                        divCnt <= divCnt - 1'b1;
                    end
                end
                DATA: begin
                    oTx <= shifter[0];
                    if (bitDone) begin
                        divCnt  <= DIV_LOAD;
                        shifter <= shifter >> 1;
                        if (bitCnt == LAST_BIT) begin
                            stopCnt <= 1'b0;
                            state   <= STOP;
                        end else begin
                            bitCnt <= bitCnt + 1'b1;
                        end
                    end else begin
                        divCnt <= divCnt - 1'b1;
                    end
                end
                STOP: begin
                    oTx <= 1'b1;
                    if (bitDone) begin
                        divCnt <= DIV_LOAD;
                        if (lastStop) begin
                            if (fifoPop) begin
                                shifter <= fifoData;
                                state   <= START;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            stopCnt <= 1'b1;
                        end
                    end else begin
                        divCnt <= divCnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
